// File: rtl/mult_div_if.sv
// Funct encodings and the EX-stage HI/LO multiply/divide bus.
// The decode package is shared by the unit and anything that drives it.
package mult_div_pkg;
  localparam logic [5:0] FUNCT_MULT   = 6'h18;
  localparam logic [5:0] FUNCT_MULTU  = 6'h19;
  localparam logic [5:0] FUNCT_DIV    = 6'h1a;
  localparam logic [5:0] FUNCT_DIVU   = 6'h1b;
  // SPECIAL2 codes remapped by ID into otherwise unused SPECIAL slots
  localparam logic [5:0] FUNCT2_MADD  = 6'h1c;
  localparam logic [5:0] FUNCT2_MADDU = 6'h1d;
  localparam logic [5:0] FUNCT2_MSUB  = 6'h1e;
  localparam logic [5:0] FUNCT2_MSUBU = 6'h1f;

  typedef enum logic [1:0] {ACC_NONE, ACC_ADD, ACC_SUB} acc_mode_t;
endpackage

interface mult_div_if;
  logic        flush;
  logic        start;
  logic [5:0]  funct;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [31:0] hi_in;
  logic [31:0] lo_in;
  logic        stall_req;
  logic        busy;
  logic        done;
  logic [31:0] result_hi;
  logic [31:0] result_lo;

  modport master (
    output flush, start, funct, operand_a, operand_b, hi_in, lo_in,
    input  stall_req, busy, done, result_hi, result_lo
  );

  modport slave (
    input  flush, start, funct, operand_a, operand_b, hi_in, lo_in,
    output stall_req, busy, done, result_hi, result_lo
  );
endinterface

// File: rtl/mult_div.sv
// Iterative HI/LO multiply / multiply-accumulate / restoring divide unit.
// Stalls the pipeline while working and pulses done with {HI,LO} results.
module mult_div
  import mult_div_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  mult_div_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, MUL, ACC, DIV, DONE} state_t;

  state_t      state, state_nxt;

  logic        dec_mul;
  logic        dec_div;
  logic        dec_signed;
  acc_mode_t   dec_acc;
  logic        accept;
  logic        div_zero;

  logic        op_signed;
  acc_mode_t   acc_mode;
  logic        neg_q;
  logic        neg_r;
  logic [31:0] a_q;        // multiplicand, or quotient/dividend shift register
  logic [31:0] b_q;        // multiplier, or divisor magnitude
  logic [31:0] rem;
  logic [4:0]  cnt;
  logic [63:0] product;
  logic [31:0] result_hi;
  logic [31:0] result_lo;

  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] product_nxt;
  logic [33:0] trial;
  logic        ge;
  logic [31:0] rem_nxt;
  logic [31:0] quo_nxt;

  // NOTE: every signal assigned in an always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    dec_mul    = 1'b0;
    dec_div    = 1'b0;
    dec_signed = 1'b0;
    dec_acc    = ACC_NONE;
    unique case (bus.funct)
      FUNCT_MULT:   begin dec_mul = 1'b1; dec_signed = 1'b1; end
      FUNCT_MULTU:  dec_mul = 1'b1;
      FUNCT2_MADD:  begin dec_mul = 1'b1; dec_signed = 1'b1; dec_acc = ACC_ADD; end
      FUNCT2_MADDU: begin dec_mul = 1'b1; dec_acc = ACC_ADD; end
      FUNCT2_MSUB:  begin dec_mul = 1'b1; dec_signed = 1'b1; dec_acc = ACC_SUB; end
      FUNCT2_MSUBU: begin dec_mul = 1'b1; dec_acc = ACC_SUB; end
      FUNCT_DIV:    begin dec_div = 1'b1; dec_signed = 1'b1; end
      FUNCT_DIVU:   dec_div = 1'b1;
      default: ;
    endcase
  end

  assign accept   = (state == IDLE) && bus.start && (dec_mul || dec_div) && !bus.flush;
  assign div_zero = (bus.operand_b == 32'd0);

  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: if (accept) state_nxt = dec_mul ? MUL : (div_zero ? DONE : DIV);
        MUL:  state_nxt = ACC;
        ACC:  state_nxt = DONE;
        DIV:  if (cnt == 5'd31) state_nxt = DONE;
        DONE: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Low 64 bits of a product are the same for signed and unsigned operands
  // once both are extended to 64 bits, so one multiplier serves both.
  assign a_ext       = {{32{op_signed & a_q[31]}}, a_q};
  assign b_ext       = {{32{op_signed & b_q[31]}}, b_q};
  assign product_nxt = a_ext * b_ext;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor if it fits.
  assign trial   = {1'b0, rem, a_q[31]} - {2'b00, b_q};
  assign ge      = ~trial[33];
  assign rem_nxt = ge ? trial[31:0] : {rem[30:0], a_q[31]};
  assign quo_nxt = {a_q[30:0], ge};

  // NOTE: the datapath registers are reset too; results must read as zero
  // after reset and the op kind must not leak from an abandoned operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_signed <= 1'b0;
      acc_mode  <= ACC_NONE;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      rem       <= '0;
      cnt       <= '0;
      product   <= '0;
      result_hi <= '0;
      result_lo <= '0;
    end else if (!bus.flush) begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            op_signed <= dec_signed;
            acc_mode  <= dec_acc;
            cnt       <= '0;
            rem       <= '0;
            if (dec_mul) begin
              a_q <= bus.operand_a;
              b_q <= bus.operand_b;
            end else begin
              a_q   <= (dec_signed && bus.operand_a[31]) ? -bus.operand_a : bus.operand_a;
              b_q   <= (dec_signed && bus.operand_b[31]) ? -bus.operand_b : bus.operand_b;
              neg_q <= dec_signed && (bus.operand_a[31] ^ bus.operand_b[31]);
              neg_r <= dec_signed && bus.operand_a[31];
              if (div_zero) begin
                result_hi <= bus.operand_a;
                result_lo <= 32'hffff_ffff;
              end
            end
          end
        end
        MUL: product <= product_nxt;
        ACC: begin
          unique case (acc_mode)
            ACC_ADD: {result_hi, result_lo} <= product + {bus.hi_in, bus.lo_in};
            ACC_SUB: {result_hi, result_lo} <= {bus.hi_in, bus.lo_in} - product;
            default: {result_hi, result_lo} <= product;
          endcase
        end
        DIV: begin
          a_q <= quo_nxt;
          rem <= rem_nxt;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            result_lo <= neg_q ? -quo_nxt : quo_nxt;
            result_hi <= neg_r ? -rem_nxt : rem_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.stall_req = accept || (state == MUL) || (state == ACC) || (state == DIV);
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.result_hi = result_hi;
  assign bus.result_lo = result_lo;

endmodule

// File: tb/tb_mult_div.sv
// Scoreboard bench for mult_div: directed ops push expected {HI,LO} and
// latency; a monitor pops and compares on every done pulse.
module tb_mult_div;
  import mult_div_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic [31:0] last_hi, last_lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          start_cyc;
    int          lat;
    string       name;
  } exp_t;

  exp_t sb[$];

  mult_div_if bus ();
  mult_div dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pending op", cyc);
      end else begin
        e = sb.pop_front();
        check({e.name, "_hi"}, bus.result_hi, e.hi);
        check({e.name, "_lo"}, bus.result_lo, e.lo);
        check({e.name, "_latency"}, cyc - e.start_cyc, e.lat);
      end
    end
  end

  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hin, input logic [31:0] lin,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input int lat, input string name);
    int stalls;
    bit seen;
    exp_t e;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.funct     = f;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.hi_in     = hin;
    bus.lo_in     = lin;
    #1;
    check({name, "_stall_c0"}, bus.stall_req, 1);
    e.hi = ehi; e.lo = elo; e.start_cyc = cyc; e.lat = lat; e.name = name;
    sb.push_back(e);
    stalls = bus.stall_req ? 1 : 0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) seen = 1'b1;
      else if (bus.stall_req) stalls++;
    end
    check({name, "_done_seen"}, seen, 1);
    check({name, "_stall_cycles"}, stalls, (lat == 1) ? 1 : lat);
    last_hi = ehi;
    last_lo = elo;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.flush = 1'b0; bus.start = 1'b0; bus.funct = '0;
    bus.operand_a = '0; bus.operand_b = '0; bus.hi_in = '0; bus.lo_in = '0;
    #12;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_stall", bus.stall_req, 0);
    check("rst_result", {bus.result_hi, bus.result_lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(FUNCT_MULT,   32'hffff_fffe, 32'd3,         0, 0,             32'hffff_ffff, 32'hffff_fffa, 3,  "mult_neg");
    run_op(FUNCT_MULTU,  32'hffff_ffff, 32'hffff_ffff, 0, 0,             32'hffff_fffe, 32'h0000_0001, 3,  "multu_max");
    run_op(FUNCT2_MADD,  32'd1,         32'd1,         0, 32'hffff_ffff, 32'h0000_0001, 32'h0000_0000, 3,  "madd_carry");
    run_op(FUNCT2_MSUB,  32'd1,         32'd1,         0, 0,             32'hffff_ffff, 32'hffff_ffff, 3,  "msub_borrow");
    run_op(FUNCT2_MADDU, 32'h8000_0000, 32'd2,         1, 2,             32'h0000_0002, 32'h0000_0002, 3,  "maddu");
    run_op(FUNCT2_MSUBU, 32'hffff_ffff, 32'd2,         0, 5,             32'hffff_fffe, 32'h0000_0007, 3,  "msubu");
    run_op(FUNCT_DIV,    32'hffff_fff9, 32'd2,         0, 0,             32'hffff_ffff, 32'hffff_fffd, 33, "div_neg7_2");
    run_op(FUNCT_DIVU,   32'd7,         32'd0,         0, 0,             32'h0000_0007, 32'hffff_ffff, 1,  "divu_zero");
    run_op(FUNCT_DIV,    32'h8000_0000, 32'hffff_ffff, 0, 0,             32'h0000_0000, 32'h8000_0000, 33, "div_wrap");
    run_op(FUNCT_DIV,    32'd7,         32'hffff_fffe, 0, 0,             32'h0000_0001, 32'hffff_fffd, 33, "div_7_neg2");
    run_op(FUNCT_DIVU,   32'd100,       32'd7,         0, 0,             32'h0000_0002, 32'h0000_000e, 33, "divu_100_7");
    run_op(FUNCT_DIVU,   32'hffff_ffff, 32'd1,         0, 0,             32'h0000_0000, 32'hffff_ffff, 33, "divu_max_1");

    // Unrecognised funct is ignored
    @(negedge clk);
    bus.start = 1'b1; bus.funct = 6'h20;
    #1;
    check("unrec_stall", bus.stall_req, 0);
    @(negedge clk);
    bus.start = 1'b0;
    check("unrec_busy", bus.busy, 0);

    // Flush a divide at cycle 10: back to IDLE, no done, results held
    @(negedge clk);
    bus.start = 1'b1; bus.funct = FUNCT_DIV; bus.operand_a = 32'd100; bus.operand_b = 32'd3;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_busy", bus.busy, 0);
    check("flush_stall", bus.stall_req, 0);
    repeat (40) @(negedge clk);
    check("flush_results_held", {bus.result_hi, bus.result_lo}, {last_hi, last_lo});

    // Reset in the middle of a divide
    @(negedge clk);
    bus.start = 1'b1; bus.funct = FUNCT_DIVU; bus.operand_a = 32'd50; bus.operand_b = 32'd5;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    check("pre_rst_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_stall", bus.stall_req, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_result", {bus.result_hi, bus.result_lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
